mat_vec_residual: RTL and testbench
===================================

MAT_VEC_RESIDUAL -- requirements
Module: mat_vec_residual

Interface
REQ-001 Parameter SIZE, default 3: matrix dimension, SIZE >= 1.
REQ-002 Parameter PRECISION, default 16: integer bits of the fixed-point word.
REQ-003 Parameter POINT, default 8: fraction bits; word width W = PRECISION+POINT, signed two's complement.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 I_RSTn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  request a residual evaluation; sampled only in IDLE.
REQ-007 A  in  W x SIZE x SIZE  coefficient matrix, signed Q(PRECISION).(POINT).
REQ-008 x  in  W x SIZE  candidate solution vector.
REQ-009 b  in  W x SIZE  right-hand-side vector.
REQ-010 r  out  W x SIZE  residual vector, r = b - A*x, registered.
REQ-011 max_abs  out  W  largest saturated |r[i]| of the last completed run, registered.
REQ-012 busy  out  1  high from the cycle after start is accepted until done deasserts.
REQ-013 done  out  1  single-cycle pulse; r and max_abs are valid from this cycle on.

Function
REQ-014 FSM states: IDLE, MAC, ROW_END, DONE.
- IDLE -> MAC on start.
- MAC -> ROW_END when col == SIZE-1.
- ROW_END -> MAC when row < SIZE-1; ROW_END -> DONE when row == SIZE-1.
- DONE -> IDLE unconditionally.
REQ-015 On accepting start, A, x and b are latched into internal snapshot registers, and row, col and acc are cleared; input changes during a run have no effect.
REQ-016 Each MAC cycle: acc += (A[row][col] * x[col]) >>> POINT.
- Product is the full 2W-bit signed value; the shift is arithmetic.
- acc is 2W bits wide; col increments.
REQ-017 Each ROW_END cycle:
- rbuf[row] <= sat_W(b[row] - acc).
- mbuf <= max(mbuf, sat_W(|sat_W(b[row]-acc)|)).
- acc and col clear; row increments.
REQ-018 sat_W clamps to the range [-2^(W-1), 2^(W-1)-1]; |-2^(W-1)| saturates to 2^(W-1)-1.
REQ-019 On the DONE entry edge, r <= rbuf and max_abs <= mbuf atomically; r and max_abs hold their values at all other times.
REQ-020 Latency: done is high exactly SIZE*(SIZE+1) cycles after the start-accept edge (12 for SIZE=3); the next start is accepted one cycle after done.
REQ-021 start while busy or done is ignored and not queued; start held high re-triggers from IDLE.
REQ-022 mbuf is cleared on start accept, so max_abs reflects only the last run.

Reset
REQ-023 When I_RSTn is low at a clock edge, regardless of state:
- state <= IDLE; row, col, acc and mbuf <= 0.
- r <= all 0; max_abs <= 0; busy <= 0; done <= 0.
REQ-024 A reset during MAC or ROW_END aborts the run; no partial result reaches r.

Structure
REQ-025 Shared package discrete_math_pkg holds the FSM state typedef and the sat_W and abs-saturate functions, parameterised by width, for reuse by the jacobi solver.
REQ-026 One sub-module, fxp_mac: a registered signed multiply, shift by POINT, and accumulate, with a clear input.

Verification
REQ-027 SIZE=3, POINT=8:
- A = diag(256), x = b = [256, 512, 768], start -> after 12 cycles r = [0, 0, 0], max_abs = 0, done pulses once.
REQ-028 A = [[512,256,0],[256,768,256],[0,256,1024]], x = [256,256,256], b = [768,1280,1024] -> r = [0, 0, -256], max_abs = 256.
REQ-029 Saturation: A[0][0] = 0x400000, x[0] = 0x400000, all other A, x, b entries 0 -> r[0] = 0x800000 (-2^23), max_abs = 0x7FFFFF.
REQ-030 Handshake and snapshot:
- start is re-pulsed at cycle 5 of a run and inputs change mid-run -> exactly one done, with the result computed from the latched inputs.
- busy is high for exactly 12 cycles.
REQ-031 Reset mid-run:
- I_RSTn low at cycle 7 -> busy = 0, done never pulses, r and max_abs = 0.
- A fresh start after reset completes correctly.

Source files
------------

// File: rtl/discrete_math_pkg.sv
// Shared discrete-math helpers: residual FSM state type and width-generic
// saturation functions (also used by the jacobi solver).
package discrete_math_pkg;

  // Working width of the saturation helpers; callers sign-extend into it.
  localparam int SAT_MAXW = 128;
  localparam logic signed [SAT_MAXW-1:0] SAT_ONE = {{(SAT_MAXW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MAC     = 2'd1,
    ST_ROW_END = 2'd2,
    ST_DONE    = 2'd3
  } mvr_state_e;

  // Clamp v into the signed range of a w-bit word.
  function automatic logic signed [SAT_MAXW-1:0] sat_w(
    input logic signed [SAT_MAXW-1:0] v,
    input int                         w
  );
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    logic signed [SAT_MAXW-1:0] res;
    hi = (SAT_ONE <<< (w - 1)) - SAT_ONE;
    lo = ~hi;
    if (v > hi) begin
      res = hi;
    end else if (v < lo) begin
      res = lo;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Magnitude of v, saturated to the positive range of a w-bit word
  // (so the most negative word maps to the largest positive one).
  function automatic logic signed [SAT_MAXW-1:0] abs_sat_w(
    input logic signed [SAT_MAXW-1:0] v,
    input int                         w
  );
    logic signed [SAT_MAXW-1:0] mag;
    if (v[SAT_MAXW-1]) begin
      mag = ~v + SAT_ONE;
    end else begin
      mag = v;
    end
    return sat_w(mag, w);
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Fixed-point multiply-accumulate: acc += (a*b) >>> POINT, full 2W-bit
// product and accumulator, with synchronous clear.
module fxp_mac #(
  parameter int W     = 24,
  parameter int POINT = 8
) (
  input  logic           clk,
  input  logic           I_RSTn,
  input  logic           clr,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc
);

  logic signed [2*W-1:0] a_ext_s;
  logic signed [2*W-1:0] b_ext_s;
  logic signed [2*W-1:0] prod_s;
  logic signed [2*W-1:0] term_s;
  logic signed [2*W-1:0] acc_r;

  // Sign-extend operands so the product is the exact signed 2W-bit value.
  always_comb begin
    a_ext_s = {{W{a[W-1]}}, a};
    b_ext_s = {{W{b[W-1]}}, b};
    prod_s  = a_ext_s * b_ext_s;
    term_s  = prod_s >>> POINT;
  end

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + term_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/mat_vec_residual.sv
// Residual r = b - A*x over a latched snapshot of the inputs, one MAC per
// cycle, plus the largest saturated |r[i]| of the run.
module mat_vec_residual
  import discrete_math_pkg::*;
#(
  parameter  int SIZE      = 3,
  parameter  int PRECISION = 16,
  parameter  int POINT     = 8,
  localparam int W         = PRECISION + POINT
) (
  input  logic                             clk,
  input  logic                             I_RSTn,
  input  logic                             start,
  input  logic [SIZE-1:0][SIZE-1:0][W-1:0] A,
  input  logic [SIZE-1:0][W-1:0]           x,
  input  logic [SIZE-1:0][W-1:0]           b,
  output logic [SIZE-1:0][W-1:0]           r,
  output logic [W-1:0]                     max_abs,
  output logic                             busy,
  output logic                             done
);

  localparam int            CW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);

  mvr_state_e                       state_r, next_state_s;
  logic [CW-1:0]                    row_r, col_r;
  logic [SIZE-1:0][SIZE-1:0][W-1:0] a_q_r;
  logic [SIZE-1:0][W-1:0]           x_q_r, b_q_r;
  logic [SIZE-1:0][W-1:0]           rbuf_r, rbuf_next_s, r_r;
  logic [W-1:0]                     mbuf_r, mbuf_next_s, max_abs_r;
  logic                             busy_r, done_r;

  logic                             mac_clr_s, mac_en_s;
  logic [W-1:0]                     mac_a_s, mac_b_s, b_row_s, row_res_s;
  logic [2*W-1:0]                   acc_s;
  logic signed [SAT_MAXW-1:0]       diff_s, sat_full_s, abs_full_s, mbuf_ext_s;

  fxp_mac #(.W(W), .POINT(POINT)) u_mac (
    .clk    (clk),
    .I_RSTn (I_RSTn),
    .clr    (mac_clr_s),
    .en     (mac_en_s),
    .a      (mac_a_s),
    .b      (mac_b_s),
    .acc    (acc_s)
  );

  // Next-state logic and MAC control.
  always_comb begin
    next_state_s = state_r;
    mac_en_s     = 1'b0;
    mac_clr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_MAC;
          mac_clr_s    = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        mac_en_s = 1'b1;
        if (col_r == LAST_IDX) begin
          next_state_s = ST_ROW_END;
        end else begin
          next_state_s = ST_MAC;
        end
      end
      ST_ROW_END: begin
        mac_clr_s = 1'b1;
        if (row_r == LAST_IDX) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_MAC;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Row residual, its saturated magnitude and the updated buffers.
  always_comb begin
    mac_a_s     = a_q_r[row_r][col_r];
    mac_b_s     = x_q_r[col_r];
    b_row_s     = b_q_r[row_r];
    diff_s      = {{(SAT_MAXW-W){b_row_s[W-1]}}, b_row_s}
                - {{(SAT_MAXW-2*W){acc_s[2*W-1]}}, acc_s};
    sat_full_s  = sat_w(diff_s, W);
    row_res_s   = sat_full_s[W-1:0];
    abs_full_s  = abs_sat_w(sat_full_s, W);
    mbuf_ext_s  = {{(SAT_MAXW-W){1'b0}}, mbuf_r};
    if (abs_full_s > mbuf_ext_s) begin
      mbuf_next_s = abs_full_s[W-1:0];
    end else begin
      mbuf_next_s = mbuf_r;
    end
    rbuf_next_s        = rbuf_r;
    rbuf_next_s[row_r] = row_res_s;
  end

  // State, counters, input snapshot and registered results.
  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_r   <= ST_IDLE;
      row_r     <= '0;
      col_r     <= '0;
      a_q_r     <= '0;
      x_q_r     <= '0;
      b_q_r     <= '0;
      rbuf_r    <= '0;
      mbuf_r    <= '0;
      r_r       <= '0;
      max_abs_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (state_r == ST_MAC) || (state_r == ST_ROW_END);
      done_r  <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_q_r  <= A;
            x_q_r  <= x;
            b_q_r  <= b;
            row_r  <= '0;
            col_r  <= '0;
            mbuf_r <= '0;
          end
        end
        ST_MAC: begin
          if (col_r != LAST_IDX) begin
            col_r <= col_r + IDX_ONE;
          end
        end
        ST_ROW_END: begin
          rbuf_r <= rbuf_next_s;
          mbuf_r <= mbuf_next_s;
          col_r  <= '0;
          if (row_r != LAST_IDX) begin
            row_r <= row_r + IDX_ONE;
          end else begin
            // Last row: publish the whole result on the DONE entry edge.
            r_r       <= rbuf_next_s;
            max_abs_r <= mbuf_next_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign r       = r_r;
  assign max_abs = max_abs_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_mat_vec_residual.sv
// Randomised self-checking bench for mat_vec_residual (SIZE=3, Q16.8).
module tb_mat_vec_residual;

  localparam int SIZE = 3;
  localparam int W    = 24;
  localparam int LAT  = SIZE * (SIZE + 1);

  logic                             clk = 1'b0;
  logic                             I_RSTn;
  logic                             start;
  logic [SIZE-1:0][SIZE-1:0][W-1:0] A;
  logic [SIZE-1:0][W-1:0]           x, b, r;
  logic [W-1:0]                     max_abs;
  logic                             busy, done;

  int     m_a [SIZE][SIZE];
  int     m_x [SIZE];
  int     m_b [SIZE];
  longint exp_r [SIZE];
  longint exp_m;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  mat_vec_residual #(.SIZE(SIZE), .PRECISION(16), .POINT(8)) dut (
    .clk     (clk),
    .I_RSTn  (I_RSTn),
    .start   (start),
    .A       (A),
    .x       (x),
    .b       (b),
    .r       (r),
    .max_abs (max_abs),
    .busy    (busy),
    .done    (done)
  );

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat24(input longint v);
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the model arrays.
  task automatic compute_expected();
    exp_m = 0;
    for (int i = 0; i < SIZE; i++) begin
      longint acc;
      longint d;
      longint mag;
      acc = 0;
      for (int j = 0; j < SIZE; j++) begin
        longint p;
        p   = longint'(m_a[i][j]) * longint'(m_x[j]);
        acc = acc + (p >>> 8);
        acc = (acc <<< 16) >>> 16;   // 48-bit accumulator wrap
      end
      d        = sat24(longint'(m_b[i]) - acc);
      exp_r[i] = d;
      mag      = sat24((d < 0) ? -d : d);
      if (mag > exp_m) exp_m = mag;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) A[i][j] = m_a[i][j][W-1:0];
      x[i] = m_x[i][W-1:0];
      b[i] = m_b[i][W-1:0];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) m_a[i][j] = 0;
      m_x[i] = 0;
      m_b[i] = 0;
    end
  endtask

  function automatic int rnd(input int bits);
    return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  task automatic randomize_model(input int bits);
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) m_a[i][j] = rnd(bits);
      m_x[i] = rnd(bits);
      m_b[i] = rnd(24);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < SIZE; i++)
      check_val($sformatf("%s r[%0d]", tag, i), longint'($signed(r[i])), exp_r[i]);
    check_val({tag, " max_abs"}, longint'(max_abs), exp_m);
  endtask

  // One run; perturb re-pulses start and scrambles inputs mid-run,
  // rst_at > 0 drops I_RSTn for one cycle at that cycle of the run.
  task automatic run_check(input string tag, input bit perturb, input int rst_at);
    int lat, n_done, n_busy;
    compute_expected();
    drive_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; n_done = 0; n_busy = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        n_done++;
        if (lat == 0) lat = k;
      end
      if (busy) n_busy++;
      if (perturb && k == 5) begin
        start = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE; j++) A[i][j] = W'($urandom);
          x[i] = W'($urandom);
          b[i] = W'($urandom);
        end
      end
      if (perturb && k == 6) start = 1'b0;
      if (rst_at > 0 && k == rst_at)     I_RSTn = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) I_RSTn = 1'b1;
    end
    if (rst_at == 0) begin
      check_val({tag, " latency"}, lat, LAT);
      check_val({tag, " done_count"}, n_done, 1);
      check_val({tag, " busy_cycles"}, n_busy, LAT);
      check_results(tag);
    end else begin
      check_val({tag, " done_count"}, n_done, 0);
      check_val({tag, " busy"}, longint'(busy), 0);
      for (int i = 0; i < SIZE; i++) begin
        exp_r[i] = 0;
      end
      exp_m = 0;
      check_results(tag);
    end
  endtask

  initial begin
    int first_done, second_done, n_done;
    I_RSTn = 1'b0;
    start  = 1'b0;
    clear_model();
    drive_inputs();
    repeat (3) tick();
    I_RSTn = 1'b1;
    tick();

    check_val("reset busy", longint'(busy), 0);
    check_val("reset done", longint'(done), 0);
    for (int i = 0; i < SIZE; i++) exp_r[i] = 0;
    exp_m = 0;
    check_results("reset");

    // Identity-scaled matrix, zero residual.
    clear_model();
    for (int i = 0; i < SIZE; i++) begin
      m_a[i][i] = 256;
      m_x[i]    = 256 * (i + 1);
      m_b[i]    = 256 * (i + 1);
    end
    run_check("diag", 1'b0, 0);

    // Tridiagonal example.
    clear_model();
    m_a[0][0] = 512; m_a[0][1] = 256;
    m_a[1][0] = 256; m_a[1][1] = 768; m_a[1][2] = 256;
    m_a[2][1] = 256; m_a[2][2] = 1024;
    for (int i = 0; i < SIZE; i++) m_x[i] = 256;
    m_b[0] = 768; m_b[1] = 1280; m_b[2] = 1024;
    run_check("tridiag", 1'b0, 0);

    // Negative saturation and abs of the most negative word.
    clear_model();
    m_a[0][0] = 32'h0040_0000;
    m_x[0]    = 32'h0040_0000;
    run_check("sat", 1'b0, 0);

    // Random runs, alternating small and large operands, some perturbed.
    for (int t = 0; t < 8; t++) begin
      randomize_model((t % 2 == 0) ? 14 : 20);
      run_check($sformatf("rand%0d", t), (t % 3 == 1), 0);
    end

    // Start held high: back-to-back runs, one idle cycle between.
    randomize_model(16);
    compute_expected();
    drive_inputs();
    start = 1'b1;
    tick();
    first_done = 0; second_done = 0; n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = k;
        else if (second_done == 0) second_done = k;
      end
      if (second_done != 0) start = 1'b0;
    end
    start = 1'b0;
    check_val("held first_done", first_done, LAT);
    check_val("held second_done", second_done, 2 * LAT + 2);
    check_val("held done_count", n_done, 2);
    check_results("held");

    // Reset mid-run after a run that left a nonzero result.
    randomize_model(18);
    run_check("pre_rst", 1'b0, 0);
    randomize_model(18);
    run_check("mid_rst", 1'b0, 7);

    // Fresh run after reset.
    randomize_model(16);
    run_check("post_rst", 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
